motor_drive: RTL and testbench

Converts the 4-bit steering command `DIR` and the travel `direction` bit into PWM and H-bridge polarity signals for the left and right drive motors. It is the consumer of the direction controller's `DIR` bus and sits between that controller and the motor driver pins. Duty changes are ramped, and a wheel that must reverse is ramped to zero and held in a dead-time before its polarity flips.

---
 rtl/motor_drive_pkg.sv | 37 +++
 rtl/motor_drive_wheel_channel.sv | 157 +++++++++++++++
 rtl/motor_drive.sv | 112 +++++++++++
 tb/tb_motor_drive.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_drive_pkg.sv
// -----------------------------------------------------------------------------
// motor_drive_pkg
// Shared definitions for the motor drive block: steering command codes,
// travel direction values, wheel FSM state encoding and H-bridge pin patterns.
// -----------------------------------------------------------------------------
package motor_drive_pkg;

  // Steering commands from the direction controller; codes 6..15 act as STOP.
  typedef enum logic [3:0] {
    STOP         = 4'd0,
    PROCEED      = 4'd1,
    HARD_LEFT    = 4'd2,
    HARD_RIGHT   = 4'd3,
    NINETY_LEFT  = 4'd4,
    NINETY_RIGHT = 4'd5
  } dir_code_e;

  // Travel direction, also used as the per-wheel polarity value.
  localparam logic FORWARDS = 1'b0;
  localparam logic REVERSE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    RAMP_DOWN = 2'd2,
    DEAD      = 2'd3
  } wheel_state_e;

  // {in1, in2} patterns driven onto the H-bridge.
  typedef enum logic [1:0] {
    PINS_COAST = 2'b00,
    PINS_REV   = 2'b01,
    PINS_FWD   = 2'b10,
    PINS_BRAKE = 2'b11
  } bridge_pins_e;

endpackage

// File: rtl/motor_drive_wheel_channel.sv
// -----------------------------------------------------------------------------
// motor_drive_wheel_channel
// One wheel: ramps its PWM duty toward a signed target once per PWM period,
// and when the target changes sign it ramps to zero, coasts for a dead-time,
// and only then flips the H-bridge polarity.
//
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   target        - signed duty target (sign = polarity, magnitude = duty)
//   boundary      - one-clock strobe on the last count of each PWM period
//   counter       - free-running PWM counter
//   pwm           - registered PWM enable (counter < duty)
//   in1, in2      - H-bridge polarity pins
//   reversing     - high while ramping down for, or waiting out, a reversal
// -----------------------------------------------------------------------------
module motor_drive_wheel_channel
  import motor_drive_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_PERIODS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [PWM_BITS:0]   target,
  input  logic                       boundary,
  input  logic        [PWM_BITS-1:0] counter,
  output logic                       pwm,
  output logic                       in1,
  output logic                       in2,
  output logic                       reversing
);

  localparam int                  DEAD_W    = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(RAMP_STEP);
  localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_PERIODS - 1);

  wheel_state_e        state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pol_q, pol_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  bridge_pins_e        pins_q, pins_d;

  logic                tgt_neg;
  logic                tgt_nz;
  logic [PWM_BITS-1:0] tgt_mag;
  logic [PWM_BITS-1:0] diff;
  logic [PWM_BITS-1:0] toward;   // duty one ramp step closer to |target|
  logic [PWM_BITS-1:0] ramp_dn;  // duty one ramp step closer to zero

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    tgt_neg = target[PWM_BITS];
    tgt_nz  = |target;
    tgt_mag = tgt_neg ? PWM_BITS'(-target) : PWM_BITS'(target);
    diff    = '0;
    toward  = duty_q;
    if (duty_q < tgt_mag) begin
      diff   = tgt_mag - duty_q;
      toward = duty_q + ((diff > STEP) ? STEP : diff);
    end else begin
      diff   = duty_q - tgt_mag;
      toward = duty_q - ((diff > STEP) ? STEP : diff);
    end
    ramp_dn = (duty_q > STEP) ? duty_q - STEP : '0;
  end

  // Next state: everything moves only on the period boundary, so a duty or
  // pin change never truncates a pulse already in flight.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    pol_d   = pol_q;
    dead_d  = dead_q;
    pins_d  = pins_q;
    if (boundary) begin
      case (state_q)
        IDLE: begin
          if (tgt_nz) begin
            state_d = RUN;
            pol_d   = tgt_neg;
            duty_d  = toward;
          end
        end
        RUN: begin
          if (tgt_nz && (tgt_neg != pol_q)) begin
            duty_d  = ramp_dn;
            dead_d  = '0;
            state_d = (ramp_dn == '0) ? DEAD : RAMP_DOWN;
          end else begin
            duty_d = toward;
            if (!tgt_nz && (toward == '0)) state_d = IDLE;
          end
        end
        RAMP_DOWN: begin
          // Original sign came back before reaching zero: resume, no dead-time.
          if (tgt_nz && (tgt_neg == pol_q)) begin
            state_d = RUN;
            duty_d  = toward;
          end else begin
            duty_d = ramp_dn;
            dead_d = '0;
            if (ramp_dn == '0) state_d = DEAD;
          end
        end
        DEAD: begin
          // The dead-time always runs to completion; the target is only
          // looked at once it has expired.
          if (dead_q == DEAD_LAST) begin
            if (tgt_nz) begin
              state_d = RUN;
              pol_d   = tgt_neg;
              duty_d  = toward;
            end else begin
              state_d = IDLE;
            end
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      case (state_d)
        IDLE:    pins_d = PINS_BRAKE;
        DEAD:    pins_d = PINS_COAST;
        default: pins_d = (pol_d == REVERSE) ? PINS_REV : PINS_FWD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      pol_q   <= FORWARDS;
      dead_q  <= '0;
      pins_q  <= PINS_COAST;
      pwm     <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pol_q   <= pol_d;
      dead_q  <= dead_d;
      pins_q  <= pins_d;
      pwm     <= (counter < duty_q);
    end
  end

  assign in1       = pins_q[1];
  assign in2       = pins_q[0];
  assign reversing = (state_q == RAMP_DOWN) || (state_q == DEAD);

endmodule

// File: rtl/motor_drive.sv
// -----------------------------------------------------------------------------
// motor_drive
// Turns the steering command DIR and the travel direction into PWM enables
// and H-bridge polarity for the left and right drive motors.
//
// Ports:
//   clk, rst               - clock, asynchronous active-low reset
//   DIR                    - 4-bit steering command
//   direction              - FORWARDS (0) / REVERSE (1)
//   left_pwm, right_pwm    - registered PWM enables
//   left_in1/2, right_in1/2- H-bridge pins (10 fwd, 01 rev, 00 coast, 11 brake)
//   reversing              - bit0 left, bit1 right: wheel is unwinding a reversal
// -----------------------------------------------------------------------------
module motor_drive
  import motor_drive_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int FULL_DUTY    = 240,
  parameter int SLOW_DUTY    = 96,
  parameter int PIVOT_DUTY   = 160,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_PERIODS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] DIR,
  input  logic       direction,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic       left_in1,
  output logic       left_in2,
  output logic       right_in1,
  output logic       right_in2,
  output logic [1:0] reversing
);

  localparam logic signed [PWM_BITS:0] FULL_S  = (PWM_BITS + 1)'(FULL_DUTY);
  localparam logic signed [PWM_BITS:0] SLOW_S  = (PWM_BITS + 1)'(SLOW_DUTY);
  localparam logic signed [PWM_BITS:0] PIVOT_S = (PWM_BITS + 1)'(PIVOT_DUTY);

  logic [3:0]                dir_q;
  logic                      direction_q;
  logic [PWM_BITS-1:0]       counter_q;
  logic                      boundary;
  logic signed [PWM_BITS:0]  left_target, right_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q       <= STOP;
      direction_q <= FORWARDS;
      counter_q   <= '0;
    end else begin
      dir_q       <= DIR;
      direction_q <= direction;
      counter_q   <= counter_q + 1'b1;
    end
  end

  // Last count of the period; the wheels commit new duty on this edge so the
  // fresh value starts exactly as the counter wraps to zero.
  assign boundary = &counter_q;

  always_comb begin
    left_target  = '0;
    right_target = '0;
    case (dir_q)
      PROCEED:      begin left_target = FULL_S;   right_target = FULL_S;   end
      HARD_LEFT:    begin left_target = SLOW_S;   right_target = FULL_S;   end
      HARD_RIGHT:   begin left_target = FULL_S;   right_target = SLOW_S;   end
      NINETY_LEFT:  begin left_target = -PIVOT_S; right_target = PIVOT_S;  end
      NINETY_RIGHT: begin left_target = PIVOT_S;  right_target = -PIVOT_S; end
      default:      ;
    endcase
    if (direction_q == REVERSE) begin
      left_target  = -left_target;
      right_target = -right_target;
    end
  end

  motor_drive_wheel_channel #(
    .PWM_BITS    (PWM_BITS),
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_left (
    .clk      (clk),
    .rst      (rst),
    .target   (left_target),
    .boundary (boundary),
    .counter  (counter_q),
    .pwm      (left_pwm),
    .in1      (left_in1),
    .in2      (left_in2),
    .reversing(reversing[0])
  );

  motor_drive_wheel_channel #(
    .PWM_BITS    (PWM_BITS),
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_right (
    .clk      (clk),
    .rst      (rst),
    .target   (right_target),
    .boundary (boundary),
    .counter  (counter_q),
    .pwm      (right_pwm),
    .in1      (right_in1),
    .in2      (right_in2),
    .reversing(reversing[1])
  );

endmodule

// File: tb/tb_motor_drive.sv
// -----------------------------------------------------------------------------
// tb_motor_drive
// Drives directed and random steering commands one PWM period at a time,
// measures the high time of each PWM output over every period, and compares
// duty, bridge pins and the reversing flags against a period-level model.
// -----------------------------------------------------------------------------
module tb_motor_drive;

  localparam int PERIOD = 256;
  localparam int FULL   = 240;
  localparam int SLOW   = 96;
  localparam int PIVOT  = 160;
  localparam int STEP   = 8;
  localparam int DEADP  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] DIR = 4'd0;
  logic       direction = 1'b0;
  logic       left_pwm, right_pwm;
  logic       left_in1, left_in2, right_in1, right_in2;
  logic [1:0] reversing;

  int total = 0;
  int bad   = 0;

  // Period-level wheel model: duty, polarity (+1/-1), braked (idle),
  // unwinding toward a reversal, remaining coast periods, and "no boundary
  // seen since reset".
  int m_duty [2];
  int m_sgn  [2];
  bit m_brake[2];
  bit m_unwind[2];
  int m_coast[2];
  bit m_fresh;

  motor_drive #(
    .PWM_BITS(8), .FULL_DUTY(FULL), .SLOW_DUTY(SLOW), .PIVOT_DUTY(PIVOT),
    .RAMP_STEP(STEP), .DEAD_PERIODS(DEADP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .DIR      (DIR),
    .direction(direction),
    .left_pwm (left_pwm),
    .right_pwm(right_pwm),
    .left_in1 (left_in1),
    .left_in2 (left_in2),
    .right_in1(right_in1),
    .right_in2(right_in2),
    .reversing(reversing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int toward(input int cur, input int goal);
    int d;
    d = goal - cur;
    if (d > STEP)  d = STEP;
    if (d < -STEP) d = -STEP;
    return cur + d;
  endfunction

  function automatic void targets(input logic [3:0] d, input logic dn,
                                  output int tl, output int tr);
    case (d)
      4'd1:    begin tl = FULL;   tr = FULL;   end
      4'd2:    begin tl = SLOW;   tr = FULL;   end
      4'd3:    begin tl = FULL;   tr = SLOW;   end
      4'd4:    begin tl = -PIVOT; tr = PIVOT;  end
      4'd5:    begin tl = PIVOT;  tr = -PIVOT; end
      default: begin tl = 0;      tr = 0;      end
    endcase
    if (dn) begin tl = -tl; tr = -tr; end
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_duty[w] = 0; m_sgn[w] = 1; m_brake[w] = 1; m_unwind[w] = 0; m_coast[w] = 0;
    end
    m_fresh = 1;
  endtask

  task automatic model_wheel(input int w, input int t);
    int mag;
    int sg;
    mag = (t < 0) ? -t : t;
    sg  = (t < 0) ? -1 : 1;
    if (m_coast[w] > 0) begin
      m_coast[w]--;
      if (m_coast[w] == 0) begin
        if (t != 0) begin m_sgn[w] = sg; m_duty[w] = toward(0, mag); end
        else m_brake[w] = 1;
      end
    end else if (m_brake[w]) begin
      if (t != 0) begin m_brake[w] = 0; m_sgn[w] = sg; m_duty[w] = toward(0, mag); end
    end else if (m_unwind[w]) begin
      if (t != 0 && sg == m_sgn[w]) begin
        m_unwind[w] = 0;
        m_duty[w]   = toward(m_duty[w], mag);
      end else begin
        m_duty[w] = toward(m_duty[w], 0);
        if (m_duty[w] == 0) begin m_unwind[w] = 0; m_coast[w] = DEADP; end
      end
    end else begin
      if (t != 0 && sg != m_sgn[w]) begin
        m_duty[w] = toward(m_duty[w], 0);
        if (m_duty[w] == 0) m_coast[w] = DEADP;
        else                m_unwind[w] = 1;
      end else begin
        m_duty[w] = toward(m_duty[w], mag);
        if (t == 0 && m_duty[w] == 0) m_brake[w] = 1;
      end
    end
  endtask

  function automatic int exp_pins(input int w);
    if (m_fresh)        return 0;
    if (m_coast[w] > 0) return 0;
    if (m_brake[w])     return 3;
    return (m_sgn[w] > 0) ? 2 : 1;
  endfunction

  function automatic int exp_rev();
    int r;
    r = 0;
    if (m_unwind[0] || m_coast[0] > 0) r += 1;
    if (m_unwind[1] || m_coast[1] > 0) r += 2;
    return r;
  endfunction

  // Entered on the falling edge just after a period boundary (or reset
  // release); leaves on the falling edge just after the next boundary.
  task automatic period(input logic [3:0] d, input logic dn);
    int hl, hr, tl, tr;
    hl = 0; hr = 0;
    DIR = d; direction = dn;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      hl += int'(left_pwm);
      hr += int'(right_pwm);
    end
    check("left_duty", hl, m_duty[0]);
    check("right_duty", hr, m_duty[1]);
    targets(d, dn, tl, tr);
    model_wheel(0, tl);
    model_wheel(1, tr);
    m_fresh = 0;
    check("left_pins", int'({left_in1, left_in2}), exp_pins(0));
    check("right_pins", int'({right_in1, right_in2}), exp_pins(1));
    check("reversing", int'(reversing), exp_rev());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lpwm"}, int'(left_pwm), 0);
    check({tag, "_rpwm"}, int'(right_pwm), 0);
    check({tag, "_lpins"}, int'({left_in1, left_in2}), 0);
    check({tag, "_rpins"}, int'({right_in1, right_in2}), 0);
    check({tag, "_rev"}, int'(reversing), 0);
  endtask

  initial begin
    int rp;
    logic [3:0] rd;
    logic       rdn;
    int         n;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    model_reset();

    // STOP: PWM stays low, brake pins after the first boundary
    repeat (2) period(4'd0, 1'b0);

    // PROCEED ramp 8..240, then settled
    repeat (31) period(4'd1, 1'b0);

    // HARD_LEFT: left 240 -> 96, right stays, no reversal
    repeat (19) period(4'd2, 1'b0);
    repeat (19) period(4'd1, 1'b0);

    // NINETY_LEFT aborted at duty 120, PROCEED restored: no dead-time
    repeat (15) period(4'd4, 1'b0);
    repeat (16) period(4'd1, 1'b0);

    // Full pivot: ramp down, dead-time, reverse ramp to 160
    repeat (56) period(4'd4, 1'b0);

    // Asynchronous reset mid-ramp at duty 64
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (8) period(4'd1, 1'b0);
    DIR = 4'd1;
    repeat (10) @(negedge clk);
    check("pwm_before_reset", int'(left_pwm), 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midramp_reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (4) period(4'd1, 1'b0);

    // Random commands, each held for a few periods
    rp = 0;
    while (rp < 80) begin
      rd  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) rd = 4'($urandom_range(0, 5));
      rdn = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 10);
      for (int k = 0; k < n && rp < 80; k++) begin
        period(rd, rdn);
        rp++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
